// File: rtl/pll_lock_rst_seq_pkg.sv
// Shared types and helpers for the PLL lock / staged reset sequencer.
// State encoding, 8-bit event counter limit and its saturating increment.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [7:0] CNT8_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == CNT8_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pll_lock_rst_seq_sync_2ff.sv
// Two-flop synchroniser for slow level signals crossing into the clk domain.
// Both flops clear to 0 on rst so an unknown input reads as "not locked".
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_rst_seq.sv
// PLL reset pulse and staged design-reset release driven by a synchronised PLL lock.
// Optional macro PLL_RST_RETRY_EN: a relock timeout re-pulses the PLL reset.
//
// state     | meaning
// PLL_RST   | pll_rst_o high for PLL_RST_CYC cycles
// WAIT_LOCK | PLL running, waiting for lock, timeout timer active
// STABLE    | counting consecutive locked cycles
// RELEASE   | dropping rst_o bits one stage gap apart
// RUN       | all resets released, ready_o high
module pll_lock_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int NUM_RST            = 3,
  parameter int PLL_RST_CYC        = 16,
  parameter int LOCK_STABLE_CYC    = 1024,
  parameter int STAGE_GAP_CYC      = 16,
  parameter int RELOCK_TIMEOUT_CYC = 65536
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock_i,
  output logic               pll_rst_o,
  output logic [NUM_RST-1:0] rst_o,
  output logic               ready_o,
  output logic [7:0]         loss_cnt_o,
  output logic [7:0]         timeout_cnt_o
);

  localparam int REL_CYC = NUM_RST * STAGE_GAP_CYC;
  localparam int W_PLL   = $clog2(PLL_RST_CYC + 1);
  localparam int W_STB   = $clog2(LOCK_STABLE_CYC + 1);
  localparam int W_REL   = $clog2(REL_CYC + 1);
  localparam int W_TMO   = $clog2(RELOCK_TIMEOUT_CYC + 1);
  localparam int W_AB    = (W_PLL > W_STB) ? W_PLL : W_STB;
  localparam int W_CD    = (W_REL > W_TMO) ? W_REL : W_TMO;
  localparam int CNT_W   = (W_AB > W_CD) ? W_AB : W_CD;

  localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RELOCK_TIMEOUT_CYC - 1);

  logic               w_lock_s;
  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [7:0]         r_loss_cnt, w_loss_nxt;
  logic [7:0]         r_tmo_cnt, w_tmo_nxt;
  logic               r_pll_rst, w_pll_rst_nxt;
  logic [NUM_RST-1:0] r_rst, w_rst_nxt;
  logic               r_ready, w_ready_nxt;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_lock_i),
    .o_q (w_lock_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= PLL_RST;
      r_cnt      <= '0;
      r_loss_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_pll_rst  <= 1'b1;
      r_rst      <= '1;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_loss_cnt <= w_loss_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
      r_pll_rst  <= w_pll_rst_nxt;
      r_rst      <= w_rst_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_loss_nxt  = r_loss_cnt;
    w_tmo_nxt   = r_tmo_cnt;
    case (r_state)
      PLL_RST: begin
        if (r_cnt == PLL_LAST) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TMO_LAST) begin
          w_cnt_nxt = '0;
          w_tmo_nxt = sat_inc8(r_tmo_cnt);
`ifdef PLL_RST_RETRY_EN
          w_state_nxt = PLL_RST;
`else
          w_state_nxt = WAIT_LOCK;
`endif
        end
      end
      STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == STB_LAST) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == REL_LAST) begin
          w_state_nxt = RUN;
          w_cnt_nxt   = '0;
        end
      end
      RUN: begin
        w_cnt_nxt = '0;
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_loss_nxt  = sat_inc8(r_loss_cnt);
        end
      end
      default: begin
        w_state_nxt = PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered so the reset lines never glitch.
  always_comb begin
    w_pll_rst_nxt = (w_state_nxt == PLL_RST);
    w_ready_nxt   = (w_state_nxt == RUN);
    w_rst_nxt     = '1;
    if (w_state_nxt == RUN) begin
      w_rst_nxt = '0;
    end else if (w_state_nxt == RELEASE) begin
      for (int k = 0; k < NUM_RST; k++) begin
        w_rst_nxt[k] = !(int'(w_cnt_nxt) >= k * STAGE_GAP_CYC);
      end
    end
  end

  assign pll_rst_o     = r_pll_rst;
  assign rst_o         = r_rst;
  assign ready_o       = r_ready;
  assign loss_cnt_o    = r_loss_cnt;
  assign timeout_cnt_o = r_tmo_cnt;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed bench for pll_lock_rst_seq with short timing parameters.
// Edge k is the k-th clk rising edge after rst deasserts; outputs are sampled 1 unit after it.
module tb_pll_lock_rst_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock_i = 1'b0;
  logic       pll_rst_o;
  logic [2:0] rst_o;
  logic       ready_o;
  logic [7:0] loss_cnt_o;
  logic [7:0] timeout_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  pll_lock_rst_seq #(
    .NUM_RST            (3),
    .PLL_RST_CYC        (4),
    .LOCK_STABLE_CYC    (8),
    .STAGE_GAP_CYC      (4),
    .RELOCK_TIMEOUT_CYC (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pll_lock_i    (pll_lock_i),
    .pll_rst_o     (pll_rst_o),
    .rst_o         (rst_o),
    .ready_o       (ready_o),
    .loss_cnt_o    (loss_cnt_o),
    .timeout_cnt_o (timeout_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired n_total=%0d", n_total);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1 unit after an edge with rst low; the next edge is edge 0.
  task automatic do_reset(input logic lock);
    pll_lock_i = lock;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    pll_lock_i = 1'b0;
    rst = 1'b1;
    step(3);
    n_total++;
    if ({pll_rst_o, rst_o, ready_o, loss_cnt_o, timeout_cnt_o} !== {1'b1, 3'b111, 1'b0, 8'd0, 8'd0})
      $display("FAIL reset_values got pll=%b rst=%b rdy=%b loss=%0d tmo=%0d exp pll=1 rst=111 rdy=0 loss=0 tmo=0",
               pll_rst_o, rst_o, ready_o, loss_cnt_o, timeout_cnt_o);
    else n_pass++;
  endtask

  task automatic test_nominal;
    logic [4:0] exp;
    do_reset(1'b0);
    for (int k = 0; k < 36; k++) begin
      step(1);
      exp = {k < 3, k < 28, k < 24, k < 20, k >= 32};
      n_total++;
      if ({pll_rst_o, rst_o, ready_o} !== exp)
        $display("FAIL nominal edge=%0d got {pll,rst,rdy}=%b exp=%b", k, {pll_rst_o, rst_o, ready_o}, exp);
      else n_pass++;
      if (k == 9) pll_lock_i = 1'b1;
    end
  endtask

  task automatic test_lock_loss;
    logic [2:0] exp_rst;
    logic       exp_rdy;
    logic [7:0] exp_loss;
    pll_lock_i = 1'b0;
    for (int j = 1; j <= 25; j++) begin
      step(1);
      if (j == 1) pll_lock_i = 1'b1;
      exp_rst  = (j < 3) ? 3'b000 : (j < 12) ? 3'b111 : (j < 16) ? 3'b110 : (j < 20) ? 3'b100 : 3'b000;
      exp_rdy  = (j < 3) || (j >= 24);
      exp_loss = (j < 3) ? 8'd0 : 8'd1;
      n_total++;
      if ({rst_o, ready_o, loss_cnt_o} !== {exp_rst, exp_rdy, exp_loss})
        $display("FAIL lock_loss j=%0d got rst=%b rdy=%b loss=%0d exp rst=%b rdy=%b loss=%0d",
                 j, rst_o, ready_o, loss_cnt_o, exp_rst, exp_rdy, exp_loss);
      else n_pass++;
    end
  endtask

  task automatic test_async_rst;
    logic [2:0] exp_rst;
    pll_lock_i = 1'b0;
    for (int j = 1; j <= 13; j++) begin
      step(1);
      if (j == 1) pll_lock_i = 1'b1;
    end
    n_total++;
    if ({rst_o, loss_cnt_o} !== {3'b110, 8'd2})
      $display("FAIL async_pre got rst=%b loss=%0d exp rst=110 loss=2", rst_o, loss_cnt_o);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({pll_rst_o, rst_o, ready_o, loss_cnt_o, timeout_cnt_o} !== {1'b1, 3'b111, 1'b0, 8'd0, 8'd0})
      $display("FAIL async_rst got pll=%b rst=%b rdy=%b loss=%0d tmo=%0d exp pll=1 rst=111 rdy=0 loss=0 tmo=0",
               pll_rst_o, rst_o, ready_o, loss_cnt_o, timeout_cnt_o);
    else n_pass++;
    step(1);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step(1);
      exp_rst = (k < 12) ? 3'b111 : 3'b110;
      n_total++;
      if ({pll_rst_o, rst_o, loss_cnt_o} !== {k < 3, exp_rst, 8'd0})
        $display("FAIL async_restart edge=%0d got pll=%b rst=%b loss=%0d exp pll=%b rst=%b loss=0",
                 k, pll_rst_o, rst_o, loss_cnt_o, k < 3, exp_rst);
      else n_pass++;
    end
  endtask

  task automatic test_glitch;
    logic [2:0] exp_rst;
    do_reset(1'b0);
    for (int k = 0; k < 30; k++) begin
      step(1);
      exp_rst = (k < 26) ? 3'b111 : 3'b110;
      n_total++;
      if ({rst_o, ready_o, loss_cnt_o} !== {exp_rst, 1'b0, 8'd0})
        $display("FAIL glitch edge=%0d got rst=%b rdy=%b loss=%0d exp rst=%b rdy=0 loss=0",
                 k, rst_o, ready_o, loss_cnt_o, exp_rst);
      else n_pass++;
      if (k == 9)  pll_lock_i = 1'b1;
      if (k == 14) pll_lock_i = 1'b0;
      if (k == 15) pll_lock_i = 1'b1;
    end
  endtask

  task automatic test_timeout;
    logic       exp_pll;
    logic [7:0] exp_tmo;
    int         m;
    do_reset(1'b0);
    for (int k = 0; k < 151; k++) begin
      step(1);
`ifdef PLL_RST_RETRY_EN
      if (k < 3) begin
        exp_pll = 1'b1;
        exp_tmo = 8'd0;
      end else begin
        m       = (k - 3) % 36;
        exp_pll = (m >= 32);
        exp_tmo = 8'((k - 3) / 36 + ((m >= 32) ? 1 : 0));
      end
`else
      exp_pll = (k < 3);
      exp_tmo = (k < 3) ? 8'd0 : 8'((k - 3) / 32);
`endif
      n_total++;
      if ({pll_rst_o, timeout_cnt_o, rst_o} !== {exp_pll, exp_tmo, 3'b111})
        $display("FAIL timeout edge=%0d got pll=%b tmo=%0d rst=%b exp pll=%b tmo=%0d rst=111",
                 k, pll_rst_o, timeout_cnt_o, rst_o, exp_pll, exp_tmo);
      else n_pass++;
    end
  endtask

  task automatic test_saturation;
    logic [7:0] exp_loss;
    do_reset(1'b1);
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < 60 && !ready_o; c++) step(1);
      if (!ready_o) begin
        n_total++;
        $display("FAIL sat_ready_timeout event=%0d got rdy=0 exp rdy=1", i);
        break;
      end
      pll_lock_i = 1'b0;
      step(1);
      pll_lock_i = 1'b1;
      step(3);
      exp_loss = (i >= 254) ? 8'd255 : 8'(i + 1);
      n_total++;
      if ({loss_cnt_o, ready_o} !== {exp_loss, 1'b0})
        $display("FAIL saturation event=%0d got loss=%0d rdy=%b exp loss=%0d rdy=0",
                 i, loss_cnt_o, ready_o, exp_loss);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_loss();
    test_async_rst();
    test_glitch();
    test_timeout();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
